// File: rtl/mem_pkg.sv
// Shared opcodes, FSM/size encodings and decode helpers for the MEM-stage
// data-memory access block.
package mem_pkg;

  localparam int TIMEOUT_DEFAULT = 16;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Anything that is not a byte or halfword access is treated as a full word.
  function automatic size_t op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
      default:              op_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic op_unsigned(input logic [5:0] op);
    return (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_aligned(input size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~lo[0];
      default: is_aligned = (lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/ack bus between the MEM stage (master) and the memory.
interface mem_access_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane from a read word and sign- or
// zero-extends it to 32 bits.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  size_t       size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
      SZ_HALF: data = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: issues one data-memory access per load/store, stalls
// upstream until the ack (or timeout), and forms the writeback values.
module mem_access
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MEM_memread,
  input  logic          MEM_memwrite,
  input  logic          MEM_memtoreg,
  input  logic          MEM_regwrite,
  input  logic          MEM_link,
  input  logic [31:0]   MEM_data_in,
  input  logic [31:0]   MEM_address_in,
  input  logic [4:0]    MEM_wraddr,
  input  logic [31:0]   MEM_pc_4,
  input  logic [31:0]   MEM_inst,
  mem_access_if.master  dm,
  output logic          mem_stall,
  output logic          mem_exc,
  output logic          WB_regwrite,
  output logic [4:0]    WB_wraddr,
  output logic [31:0]   WB_wdata
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   load_q;
  logic          err_q;

  logic [5:0]    opcode;
  size_t         size;
  logic          mem_op;
  logic          aligned;
  logic          access;
  logic          misalign;
  logic          timeout;
  logic [31:0]   load_ext;

  logic          stall_c;
  logic          req_c;
  logic          exc_c;
  logic          wb_en;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic          unused_inst;

  assign opcode      = MEM_inst[31:26];
  assign unused_inst = ^MEM_inst[25:0];
  assign size        = op_size(opcode);
  assign mem_op      = MEM_memread | MEM_memwrite;
  assign aligned     = is_aligned(size, MEM_address_in[1:0]);
  assign access      = mem_op & aligned;
  assign misalign    = mem_op & ~aligned;
  assign timeout     = (wait_cnt == CW'(TIMEOUT - 1));

  // An ack in the final wait cycle still counts as a successful access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      load_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        REQ: begin
          if (dm.dm_ack) begin
            load_q   <= dm.dm_rdata;
            wait_cnt <= '0;
          end else if (timeout) begin
            err_q    <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE: begin
          err_q    <= 1'b0;
          wait_cnt <= '0;
        end
        default: wait_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    req_c     = 1'b0;
    exc_c     = 1'b0;
    wb_en     = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          state_nxt = REQ;
          stall_c   = 1'b1;
        end else begin
          exc_c = misalign;
          wb_en = MEM_regwrite & ~misalign;
        end
      end
      REQ: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        if (dm.dm_ack || timeout) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        exc_c     = err_q;
        wb_en     = MEM_regwrite & ~err_q;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lane enables and replicated store data follow the access size.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = MEM_data_in;
    case (size)
      SZ_BYTE: begin
        be_c    = 4'b0001 << MEM_address_in[1:0];
        wdata_c = {4{MEM_data_in[7:0]}};
      end
      SZ_HALF: begin
        be_c    = MEM_address_in[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{MEM_data_in[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = MEM_data_in;
      end
    endcase
  end

  load_align u_load_align (
    .rdata       (load_q),
    .addr_lo     (MEM_address_in[1:0]),
    .size        (size),
    .is_unsigned (op_unsigned(opcode)),
    .data        (load_ext)
  );

  assign dm.dm_req   = req_c;
  assign dm.dm_we    = MEM_memwrite;
  assign dm.dm_addr  = {MEM_address_in[31:2], 2'b00};
  assign dm.dm_be    = be_c;
  assign dm.dm_wdata = wdata_c;

  assign mem_stall   = stall_c & ~rst;
  assign mem_exc     = exc_c & ~rst;
  assign WB_regwrite = wb_en & ~rst;
  assign WB_wraddr   = MEM_wraddr;
  assign WB_wdata    = MEM_link     ? (MEM_pc_4 + 32'd4) :
                       MEM_memtoreg ? load_ext : MEM_address_in;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: loads, stores, misalignment,
// bus timeout, stray acks and reset during a request.
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        MEM_memread, MEM_memwrite, MEM_memtoreg, MEM_regwrite, MEM_link;
  logic [31:0] MEM_data_in, MEM_address_in, MEM_pc_4, MEM_inst;
  logic [4:0]  MEM_wraddr;
  logic        mem_stall, mem_exc, WB_regwrite;
  logic [4:0]  WB_wraddr;
  logic [31:0] WB_wdata;

  int vectors = 0;
  int errors  = 0;

  int          stalls, reqs;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_be;
  logic        seen_we;

  mem_access_if bus ();

  mem_access #(.TIMEOUT(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .MEM_memread    (MEM_memread),
    .MEM_memwrite   (MEM_memwrite),
    .MEM_memtoreg   (MEM_memtoreg),
    .MEM_regwrite   (MEM_regwrite),
    .MEM_link       (MEM_link),
    .MEM_data_in    (MEM_data_in),
    .MEM_address_in (MEM_address_in),
    .MEM_wraddr     (MEM_wraddr),
    .MEM_pc_4       (MEM_pc_4),
    .MEM_inst       (MEM_inst),
    .dm             (bus),
    .mem_stall      (mem_stall),
    .mem_exc        (mem_exc),
    .WB_regwrite    (WB_regwrite),
    .WB_wraddr      (WB_wraddr),
    .WB_wdata       (WB_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic m2r,
                               input logic rw, input logic lnk,
                               input logic [31:0] data, input logic [31:0] addr,
                               input logic [4:0] wraddr, input logic [31:0] pc4,
                               input logic [5:0] op);
    MEM_memread    = rd;
    MEM_memwrite   = wr;
    MEM_memtoreg   = m2r;
    MEM_regwrite   = rw;
    MEM_link       = lnk;
    MEM_data_in    = data;
    MEM_address_in = addr;
    MEM_wraddr     = wraddr;
    MEM_pc_4       = pc4;
    MEM_inst       = {op, 26'h0};
  endtask

  task automatic idleCycle();
    @(negedge clk);
    bus.dm_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 6'h00);
    #1;
  endtask

  // Presents one memory instruction and plays the memory side, acking on the
  // ack_at-th request cycle (0 = never). Returns #1 after the negedge of the
  // first cycle in which mem_stall is low.
  task automatic runAccess(input logic [5:0] op, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rdata, input int ack_at);
    int n;
    stalls = 0;
    reqs   = 0;
    n      = 0;
    seen_addr = 32'hx; seen_wdata = 32'hx; seen_be = 4'hx; seen_we = 1'bx;
    @(negedge clk);
    bus.dm_ack = 1'b0;
    applyStimulus(rd, wr, rd, rd, 1'b0, data, addr, 5'd7, 32'h400, op);
    #1;
    while (n < 40) begin
      if (!mem_stall) break;
      stalls++;
      if (bus.dm_req) begin
        reqs++;
        if (reqs == 1) begin
          seen_addr  = bus.dm_addr;
          seen_be    = bus.dm_be;
          seen_we    = bus.dm_we;
          seen_wdata = bus.dm_wdata;
        end
        if (reqs == ack_at) begin
          bus.dm_ack   = 1'b1;
          bus.dm_rdata = rdata;
        end
      end
      @(negedge clk);
      bus.dm_ack = 1'b0;
      #1;
      n++;
    end
    if (n >= 40) checkOutput("stall_bound", 32'(n), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.dm_ack   = 1'b0;
    bus.dm_rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 6'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_dm_req", 32'(bus.dm_req), 32'd0);
    checkOutput("rst_stall",  32'(mem_stall), 32'd0);
    checkOutput("rst_exc",    32'(mem_exc), 32'd0);
    checkOutput("rst_wb_en",  32'(WB_regwrite), 32'd0);
    rst = 1'b0;

    // lw 0x100, ack on third request cycle
    runAccess(6'h23, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3);
    checkOutput("lw_stalls",  32'(stalls), 32'd4);
    checkOutput("lw_reqs",    32'(reqs), 32'd3);
    checkOutput("lw_addr",    seen_addr, 32'h0000_0100);
    checkOutput("lw_wdata",   WB_wdata, 32'hDEAD_BEEF);
    checkOutput("lw_wb_en",   32'(WB_regwrite), 32'd1);
    checkOutput("lw_wraddr",  32'(WB_wraddr), 32'd7);
    checkOutput("lw_exc",     32'(mem_exc), 32'd0);

    runAccess(6'h20, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 1);
    checkOutput("lb_addr",    seen_addr, 32'h0000_0100);
    checkOutput("lb_stalls",  32'(stalls), 32'd2);
    checkOutput("lb_wdata",   WB_wdata, 32'hFFFF_FF80);

    runAccess(6'h24, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 2);
    checkOutput("lbu_wdata",  WB_wdata, 32'h0000_0080);

    runAccess(6'h21, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 32'h8765_4321, 1);
    checkOutput("lh_wdata",   WB_wdata, 32'hFFFF_8765);

    runAccess(6'h25, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h8765_F00D, 1);
    checkOutput("lhu_wdata",  WB_wdata, 32'h0000_F00D);

    runAccess(6'h29, 1'b0, 1'b1, 32'h0000_0102, 32'h0000_1234, 32'h0, 1);
    checkOutput("sh_be",      32'(seen_be), 32'hC);
    checkOutput("sh_we",      32'(seen_we), 32'd1);
    checkOutput("sh_wdata",   seen_wdata, 32'h1234_1234);
    checkOutput("sh_wb_en",   32'(WB_regwrite), 32'd0);

    runAccess(6'h28, 1'b0, 1'b1, 32'h0000_0101, 32'h0000_00AB, 32'h0, 1);
    checkOutput("sb_be",      32'(seen_be), 32'h2);
    checkOutput("sb_wdata",   seen_wdata, 32'hABAB_ABAB);

    runAccess(6'h2B, 1'b0, 1'b1, 32'h0000_0104, 32'hCAFE_0001, 32'h0, 1);
    checkOutput("sw_be",      32'(seen_be), 32'hF);
    checkOutput("sw_wdata",   seen_wdata, 32'hCAFE_0001);

    // misaligned lw: no request, no stall, one-cycle exception
    runAccess(6'h23, 1'b1, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 1);
    checkOutput("mis_lw_reqs",  32'(reqs), 32'd0);
    checkOutput("mis_lw_stall", 32'(mem_stall), 32'd0);
    checkOutput("mis_lw_dmreq", 32'(bus.dm_req), 32'd0);
    checkOutput("mis_lw_exc",   32'(mem_exc), 32'd1);
    checkOutput("mis_lw_wb_en", 32'(WB_regwrite), 32'd0);
    idleCycle();
    checkOutput("mis_lw_exc_end", 32'(mem_exc), 32'd0);

    runAccess(6'h21, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 32'h0, 1);
    checkOutput("mis_lh_exc",   32'(mem_exc), 32'd1);
    checkOutput("mis_lh_reqs",  32'(reqs), 32'd0);

    // no ack: request held TIMEOUT cycles then bus error
    runAccess(6'h23, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h0, 0);
    checkOutput("to_reqs",    32'(reqs), 32'd16);
    checkOutput("to_stalls",  32'(stalls), 32'd17);
    checkOutput("to_dmreq",   32'(bus.dm_req), 32'd0);
    checkOutput("to_exc",     32'(mem_exc), 32'd1);
    checkOutput("to_wb_en",   32'(WB_regwrite), 32'd0);
    idleCycle();
    checkOutput("to_exc_end", 32'(mem_exc), 32'd0);

    // stray ack in IDLE is ignored; ALU and link results pass through
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1234_5678, 5'd9, 32'h400, 6'h00);
    bus.dm_ack   = 1'b1;
    bus.dm_rdata = 32'h5555_5555;
    #1;
    checkOutput("alu_wdata",  WB_wdata, 32'h1234_5678);
    checkOutput("alu_wb_en",  32'(WB_regwrite), 32'd1);
    checkOutput("alu_stall",  32'(mem_stall), 32'd0);
    @(negedge clk);
    bus.dm_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h1234_5678, 5'd31, 32'h400, 6'h00);
    #1;
    checkOutput("ack_idle_dmreq", 32'(bus.dm_req), 32'd0);
    checkOutput("link_wdata", WB_wdata, 32'h0000_0404);

    // reset while a request is outstanding
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0300, 5'd4, 32'h400, 6'h23);
    @(negedge clk);
    #1;
    checkOutput("rstreq_dmreq_before", 32'(bus.dm_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rstreq_dmreq_after", 32'(bus.dm_req), 32'd0);
    checkOutput("rstreq_stall",       32'(mem_stall), 32'd0);
    checkOutput("rstreq_wb_en",       32'(WB_regwrite), 32'd0);
    rst = 1'b0;
    idleCycle();

    runAccess(6'h24, 1'b1, 1'b0, 32'h0000_0301, 32'h0, 32'h0000_7F00, 1);
    checkOutput("post_rst_lbu", WB_wdata, 32'h0000_007F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
